fetch_pc_gen: RTL and testbench
===============================

Name: fetch_pc_gen

Overview:
- Program-counter stage directly upstream of instruction fetch.
- Owns the PC register and the next-PC mux (sequential +4, redirect, stall hold).
- Drives the synchronous BIOS/IMEM read address one cycle ahead of the registered PC.
- Supplies fetch with the PC, the BIOS/IMEM select and the bubble/kill flag that replaces the fetched word with a NOP (0x00000013).

Parameters:
- RESET_PC, 32'h4000_0000, PC after reset (BIOS base).
- BIOS_REGION, 4'b0100, value of pc[31:28] that selects BIOS; anything else selects IMEM.

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold the current PC and re-read the same word (hazard unit).
- redirect_valid  in  1  taken branch/jal/jalr resolved in execute this cycle.
- redirect_pc  in  32  target PC for redirect_valid.
- addr_pc  out  32  combinational address for the BRAM read port; fetch shifts it right by 2.
- pc  out  32  registered PC, aligned with the BRAM dout of this cycle.
- inst_sel  out  1  1 = BIOS, 0 = IMEM; decoded from addr_pc and registered, so aligned with pc.
- is_j  out  1  bubble; fetch must output a NOP this cycle.
- misalign_err  out  1  sticky; set when redirect_pc[1:0] != 0.
- fetch_count  out  32  count of non-bubble, non-stalled fetches.

Behaviour:
- Reset (async, rst_n=0): state=BOOT, pc=RESET_PC, inst_sel=1, misalign_err=0, fetch_count=0. In BOOT, addr_pc=RESET_PC and is_j=1.
- BOOT -> RUN on the first clk edge with rst_n=1. pc stays RESET_PC; the BRAM has now latched RESET_PC, so dout is valid in the first RUN cycle.
- RUN next-PC priority, with addr_pc combinational:
  - redirect_valid: {redirect_pc[31:2],2'b00}.
  - else stall: pc.
  - else: pc+4.
- RUN, every edge: pc<=addr_pc; inst_sel<=(addr_pc[31:28]==BIOS_REGION).
- is_j in RUN = redirect_valid, combinational. The word at pc is younger than the resolving branch and is killed in the same cycle. Decode-register flush is outside this block.
- Redirect has priority over stall. With both asserted, the target is taken and is_j=1.
- Stall alone: pc, addr_pc and inst_sel are held. The BRAM re-reads the same address, so dout is stable next cycle. is_j=0. fetch_count is held.
- fetch_count increments on an edge in RUN when !stall && !redirect_valid. Wraps modulo 2^32 with no flag.
- misalign_err is set on an edge where redirect_valid && redirect_pc[1:0]!=0. Only reset clears it. The misaligned redirect still proceeds with the low bits forced to 0.
- pc+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000, with inst_sel recomputed (IMEM).
- Reset asserted mid-operation returns immediately to the reset values, independent of clk. Any in-flight redirect is dropped.
- No other states; BOOT is never re-entered without reset.

Decomposition:
- Shared core package holds:
  - RESET_PC and BIOS_REGION constants.
  - The NOP encoding 32'h0000_0013, also used by fetch.
  - The 2-state enum {BOOT, RUN}.
- One natural sub-module: pc_next_mux, the combinational priority mux plus alignment. The PC register, state and counters stay in the top.

Test Plan:
- Reset release, no stall/redirect for 4 cycles:
  - First cycle is_j=1, pc=0x4000_0000, inst_sel=1.
  - pc then steps 0x4000_0000, 0x4000_0004, 0x4000_0008.
  - fetch_count=3 after the third RUN edge.
- In RUN at pc=0x4000_0010, redirect_valid=1 with redirect_pc=0x0000_0100:
  - is_j=1 in that cycle, addr_pc=0x100.
  - Next cycle pc=0x100, inst_sel=0, is_j=0, fetch_count unchanged.
- stall=1 for 3 cycles at pc=0x0000_0200: pc, addr_pc and fetch_count held. When stall drops, pc=0x204 next.
- stall=1 and redirect_valid=1 together, redirect_pc=0x4000_0040: pc=0x4000_0040 next, inst_sel=1, is_j=1 in the redirect cycle.
- redirect_pc=0x0000_0102: pc=0x100 next and misalign_err=1; it stays 1 after 10 more clean cycles.
- rst_n pulsed low asynchronously between edges at pc=0x300: outputs return to reset values before the next edge, and BOOT repeats with is_j=1 for one cycle.

Source files
------------

// File: rtl/fetch_pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_pkg
// Brief    : Shared constants, NOP encoding and PC-stage state type for fetch.
// Revision : 1.0 - initial release
// ============================================================================
package fetch_pc_gen_pkg;

    localparam logic [31:0] c_reset_pc    = 32'h4000_0000;
    localparam logic [3:0]  c_bios_region = 4'b0100;
    localparam logic [31:0] c_nop_inst    = 32'h0000_0013;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } pc_state_e;

    // Memory select is decided only by the top nibble of the address.
    function automatic logic is_bios(input logic [3:0] addr_hi, input logic [3:0] region);
        return addr_hi == region;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pc_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_if
// Brief    : Control inputs and fetch-facing outputs of the PC generator.
// Revision : 1.0 - initial release
// ============================================================================
interface fetch_pc_gen_if;

    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [31:0] addr_pc;
    logic [31:0] pc;
    logic        inst_sel;
    logic        is_j;
    logic        misalign_err;
    logic [31:0] fetch_count;

    // PC generator side
    modport master (
        input  stall, redirect_valid, redirect_pc,
        output addr_pc, pc, inst_sel, is_j, misalign_err, fetch_count
    );

    // Hazard unit / execute / fetch side
    modport slave (
        output stall, redirect_valid, redirect_pc,
        input  addr_pc, pc, inst_sel, is_j, misalign_err, fetch_count
    );

endinterface
`default_nettype wire

// File: rtl/fetch_pc_gen_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen_pc_next_mux
// Brief    : Next-PC priority mux (redirect > stall > +4) with word alignment.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen_pc_next_mux (
    input  wire logic [31:0] i_pc,
    input  wire logic        i_stall,
    input  wire logic        i_redirect_valid,
    input  wire logic [31:0] i_redirect_pc,
    output logic      [31:0] o_next_pc,
    output logic             o_misaligned
);

    logic [31:0] w_seq_pc;

    // Natural 32-bit wrap from 0xFFFF_FFFC to 0 is intended.
    assign w_seq_pc = i_pc + 32'd4;

    always_comb begin
        o_next_pc = w_seq_pc;
        if (i_redirect_valid) begin
            o_next_pc = {i_redirect_pc[31:2], 2'b00};
        end else if (i_stall) begin
            o_next_pc = i_pc;
        end
    end

    assign o_misaligned = i_redirect_valid && (i_redirect_pc[1:0] != 2'b00);

endmodule
`default_nettype wire

// File: rtl/fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : fetch_pc_gen
// Brief    : PC register, BOOT/RUN sequencing and BRAM read address for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = c_reset_pc,
    parameter logic [3:0]  BIOS_REGION = c_bios_region
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    fetch_pc_gen_if.master     bus
);

    pc_state_e   r_state;
    logic [31:0] r_pc;
    logic        r_inst_sel;
    logic        r_misalign_err;
    logic [31:0] r_fetch_count;

    logic [31:0] w_mux_pc;
    logic [31:0] w_addr_pc;
    logic        w_misaligned;
    logic        w_run;

    assign w_run = (r_state == RUN);

    fetch_pc_gen_pc_next_mux u_pc_next_mux (
        .i_pc             (r_pc),
        .i_stall          (bus.stall),
        .i_redirect_valid (bus.redirect_valid),
        .i_redirect_pc    (bus.redirect_pc),
        .o_next_pc        (w_mux_pc),
        .o_misaligned     (w_misaligned)
    );

    // BOOT presents the reset address so the BRAM holds its word by the first RUN cycle.
    assign w_addr_pc = w_run ? w_mux_pc : RESET_PC;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= BOOT;
            r_pc           <= RESET_PC;
            r_inst_sel     <= 1'b1;
            r_misalign_err <= 1'b0;
            r_fetch_count  <= 32'd0;
        end else if (!w_run) begin
            r_state <= RUN;
        end else begin
            r_pc       <= w_addr_pc;
            r_inst_sel <= is_bios(w_addr_pc[31:28], BIOS_REGION);
            if (!bus.stall && !bus.redirect_valid) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_misaligned) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

    assign bus.addr_pc      = w_addr_pc;
    assign bus.pc           = r_pc;
    assign bus.inst_sel     = r_inst_sel;
    // The word at pc is younger than a resolving branch, so it is killed immediately.
    assign bus.is_j         = !w_run || bus.redirect_valid;
    assign bus.misalign_err = r_misalign_err;
    assign bus.fetch_count  = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_pc_gen
// Brief    : Randomized self-checking bench for fetch_pc_gen against a PC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_gen;

    localparam logic [31:0] c_reset_pc = 32'h4000_0000;

    logic clk;
    logic rst_n;
    fetch_pc_gen_if bus ();

    fetch_pc_gen #(
        .RESET_PC    (32'h4000_0000),
        .BIOS_REGION (4'b0100)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: architectural view of the PC stage
    logic        m_boot;
    logic [31:0] m_pc;
    logic        m_sel;
    logic [31:0] m_count;
    logic        m_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot  = 1'b1;
        m_pc    = c_reset_pc;
        m_sel   = 1'b1;
        m_count = 32'd0;
        m_err   = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        check({tag, ".pc"},       bus.pc, m_pc);
        check({tag, ".inst_sel"}, {31'd0, bus.inst_sel}, {31'd0, m_sel});
        check({tag, ".count"},    bus.fetch_count, m_count);
        check({tag, ".err"},      {31'd0, bus.misalign_err}, {31'd0, m_err});
    endtask

    // Called just after a negedge: drive, check, advance model, wait for next negedge.
    task automatic step(input logic s, input logic rv, input logic [31:0] rpc);
        logic [31:0] exp_addr;
        bus.stall          = s;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        #1;
        if (m_boot)   exp_addr = c_reset_pc;
        else if (rv)  exp_addr = rpc & 32'hFFFF_FFFC;
        else if (s)   exp_addr = m_pc;
        else          exp_addr = m_pc + 32'd4;
        check("addr_pc", bus.addr_pc, exp_addr);
        check("is_j", {31'd0, bus.is_j}, {31'd0, (m_boot || rv)});
        check_regs("step");
        if (m_boot) begin
            m_boot = 1'b0;
        end else begin
            m_pc  = exp_addr;
            m_sel = (exp_addr[31:28] == 4'h4);
            if (!s && !rv) m_count = m_count + 32'd1;
            if (rv && rpc[1:0] != 2'b00) m_err = 1'b1;
        end
        @(negedge clk);
    endtask

    // Async reset pulse strictly between edges, with a redirect in flight.
    task automatic reset_pulse(input logic [31:0] rpc);
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = rpc;
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("rst_async");
        check("rst_async.addr_pc", bus.addr_pc, c_reset_pc);
        check("rst_async.is_j", {31'd0, bus.is_j}, 32'd1);
        rst_n = 1'b1;
        #1;
        check("boot.addr_pc", bus.addr_pc, c_reset_pc);
        check("boot.is_j", {31'd0, bus.is_j}, 32'd1);
        m_boot = 1'b0;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] rpc;
        logic        s;
        logic        rv;

        rst_n              = 1'b0;
        bus.stall          = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check_regs("reset");
        check("reset.addr_pc", bus.addr_pc, c_reset_pc);
        check("reset.is_j", {31'd0, bus.is_j}, 32'd1);
        rst_n = 1'b1;

        // Boot then sequential fetch
        step(1'b0, 1'b0, 32'd0);
        repeat (3) step(1'b0, 1'b0, 32'd0);
        check("seq.count3", bus.fetch_count, 32'd3);
        check("seq.pc", bus.pc, 32'h4000_000C);
        step(1'b0, 1'b0, 32'd0);
        check("seq.pc10", bus.pc, 32'h4000_0010);

        // Redirect into IMEM
        step(1'b0, 1'b1, 32'h0000_0100);
        check("redir.pc", bus.pc, 32'h0000_0100);
        check("redir.sel", {31'd0, bus.inst_sel}, 32'd0);
        check("redir.count", bus.fetch_count, 32'd4);

        // Stall hold then release
        step(1'b0, 1'b1, 32'h0000_0200);
        repeat (3) step(1'b1, 1'b0, 32'd0);
        check("stall.pc", bus.pc, 32'h0000_0200);
        step(1'b0, 1'b0, 32'd0);
        check("stall.release", bus.pc, 32'h0000_0204);

        // Redirect wins over stall
        step(1'b1, 1'b1, 32'h4000_0040);
        check("prio.pc", bus.pc, 32'h4000_0040);
        check("prio.sel", {31'd0, bus.inst_sel}, 32'd1);

        // Misaligned redirect is sticky
        step(1'b0, 1'b1, 32'h0000_0102);
        check("mis.pc", bus.pc, 32'h0000_0100);
        repeat (10) step(1'b0, 1'b0, 32'd0);
        check("mis.sticky", {31'd0, bus.misalign_err}, 32'd1);

        // Async reset mid-run
        step(1'b0, 1'b1, 32'h0000_0300);
        reset_pulse(32'h0000_0500);
        step(1'b0, 1'b0, 32'd0);
        check("rst.resume", bus.pc, 32'h4000_0004);

        // PC wrap to IMEM
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'd0);
        check("wrap.pc", bus.pc, 32'd0);
        check("wrap.sel", {31'd0, bus.inst_sel}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            rv  = ($urandom_range(0, 6) == 0);
            rpc = $urandom;
            if ($urandom_range(0, 1) == 1) rpc[31:28] = 4'h4;
            if ($urandom_range(0, 15) == 0) rpc[31:4] = 28'hFFF_FFFF;
            if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
            if ($urandom_range(0, 99) == 0) begin
                reset_pulse(rpc);
            end else begin
                step(s, rv, rpc);
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
